// File: rtl/bcd_calendar_counter_pkg.sv
// ============================================================================
// bcd_calendar_counter_pkg : shared date constants and BCD helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_calendar_counter_pkg;

  localparam logic [7:0] DEF_YEAR  = 8'h00;
  localparam logic [7:0] DEF_MONTH = 8'h01;
  localparam logic [7:0] DEF_DAY   = 8'h01;

  localparam logic [7:0] MON_JAN = 8'h01;
  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_MAR = 8'h03;
  localparam logic [7:0] MON_APR = 8'h04;
  localparam logic [7:0] MON_MAY = 8'h05;
  localparam logic [7:0] MON_JUN = 8'h06;
  localparam logic [7:0] MON_JUL = 8'h07;
  localparam logic [7:0] MON_AUG = 8'h08;
  localparam logic [7:0] MON_SEP = 8'h09;
  localparam logic [7:0] MON_OCT = 8'h10;
  localparam logic [7:0] MON_NOV = 8'h11;
  localparam logic [7:0] MON_DEC = 8'h12;

  localparam logic [7:0] DAYS_28 = 8'h28;
  localparam logic [7:0] DAYS_29 = 8'h29;
  localparam logic [7:0] DAYS_30 = 8'h30;
  localparam logic [7:0] DAYS_31 = 8'h31;

  function automatic logic is_long_month(input logic [7:0] m);
    return (m == MON_JAN) || (m == MON_MAR) || (m == MON_MAY) || (m == MON_JUL) ||
           (m == MON_AUG) || (m == MON_OCT) || (m == MON_DEC);
  endfunction

  function automatic logic is_short_month(input logic [7:0] m);
    return (m == MON_APR) || (m == MON_JUN) || (m == MON_SEP) || (m == MON_NOV);
  endfunction

  // Century-free leap rule: 2000 is a leap year, so 20YY is leap iff YY % 4 == 0.
  function automatic logic is_leap_year(input logic [7:0] yy);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = yy[7:4];
    ones = yy[3:0];
    return (!tens[0] && (ones == 4'd0 || ones == 4'd4 || ones == 4'd8)) ||
           ( tens[0] && (ones == 4'd2 || ones == 4'd6));
  endfunction

  function automatic logic nibbles_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    if (b[3:0] == 4'd9)
      return {b[7:4] + 4'd1, 4'd0};
    else
      return {b[7:4], b[3:0] + 4'd1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_calendar_counter_month_len.sv
// ============================================================================
// bcd_calendar_counter_month_len : BCD last day of a BCD month/year (00 if bad month)
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_calendar_counter_month_len
  import bcd_calendar_counter_pkg::*;
(
  input  logic [7:0] month,
  input  logic [7:0] year,
  output logic [7:0] last_day
);

  // An unrecognised month code yields 00, which no day can satisfy.
  always_comb begin
    last_day = 8'h00;
    if (is_long_month(month))
      last_day = DAYS_31;
    else if (is_short_month(month))
      last_day = DAYS_30;
    else if (month == MON_FEB)
      last_day = is_leap_year(year) ? DAYS_29 : DAYS_28;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_calendar_counter.sv
// ============================================================================
// bcd_calendar_counter : BCD 20YY-MM-DD day counter with validated load
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_calendar_counter
  import bcd_calendar_counter_pkg::*;
#(
  parameter logic [7:0] RST_YEAR  = DEF_YEAR,
  parameter logic [7:0] RST_MONTH = DEF_MONTH,
  parameter logic [7:0] RST_DAY   = DEF_DAY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_yy,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_dd,
  output logic [3:0] value0,
  output logic [3:0] value1,
  output logic [3:0] value2,
  output logic [3:0] value3,
  output logic [3:0] value4,
  output logic [3:0] value5,
  output logic       wrap,
  output logic       load_err
);

  logic [7:0] day, month, year;
  logic [7:0] day_next, month_next, year_next;
  logic       wrap_next, err_next;
  logic [7:0] cur_last, load_last;
  logic       load_ok;

  bcd_calendar_counter_month_len u_len_cur (
    .month    (month),
    .year     (year),
    .last_day (cur_last)
  );

  bcd_calendar_counter_month_len u_len_load (
    .month    (load_mm),
    .year     (load_yy),
    .last_day (load_last)
  );

  // With every nibble <= 9, BCD bytes order the same as their decimal values.
  assign load_ok = nibbles_ok(load_yy) && nibbles_ok(load_mm) && nibbles_ok(load_dd) &&
                   (load_last != 8'h00) && (load_dd != 8'h00) && (load_dd <= load_last);

  always_comb begin
    day_next   = day;
    month_next = month;
    year_next  = year;
    wrap_next  = 1'b0;
    err_next   = 1'b0;
    if (load) begin
      if (load_ok) begin
        day_next   = load_dd;
        month_next = load_mm;
        year_next  = load_yy;
      end else begin
        err_next = 1'b1;
      end
    end else if (en) begin
      if (day != cur_last) begin
        day_next = bcd_inc(day);
      end else begin
        day_next = 8'h01;
        if (month == MON_DEC) begin
          month_next = MON_JAN;
          if (year == 8'h99) begin
            year_next = 8'h00;
            wrap_next = 1'b1;
          end else begin
            year_next = bcd_inc(year);
          end
        end else begin
          month_next = bcd_inc(month);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day      <= RST_DAY;
      month    <= RST_MONTH;
      year     <= RST_YEAR;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      day      <= day_next;
      month    <= month_next;
      year     <= year_next;
      wrap     <= wrap_next;
      load_err <= err_next;
    end
  end

  assign value0 = day[3:0];
  assign value1 = day[7:4];
  assign value2 = month[3:0];
  assign value3 = month[7:4];
  assign value4 = year[3:0];
  assign value5 = year[7:4];

endmodule

`default_nettype wire

// File: tb/tb_bcd_calendar_counter.sv
// ============================================================================
// tb_bcd_calendar_counter : scoreboard bench with an integer calendar model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_calendar_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_yy = 8'h00, load_mm = 8'h00, load_dd = 8'h00;
  logic [3:0] value0, value1, value2, value3, value4, value5;
  logic       wrap, load_err;

  bcd_calendar_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_yy  (load_yy),
    .load_mm  (load_mm),
    .load_dd  (load_dd),
    .value0   (value0),
    .value1   (value1),
    .value2   (value2),
    .value3   (value3),
    .value4   (value4),
    .value5   (value5),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [25:0] exp_q[$];
  logic [25:0] actual;
  int m_year = 0, m_month = 1, m_day = 1;

  assign actual = {value5, value4, value3, value2, value1, value0, wrap, load_err};

  function automatic int dim(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic bit nib_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got yymmdd=%h wrap=%b err=%b, expected yymmdd=%h wrap=%b err=%b",
               name, got[25:2], got[1], got[0], exp[25:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input bit ld, input bit e, input logic [7:0] yy,
                      input logic [7:0] mm, input logic [7:0] dd);
    bit w, le;
    int ly, lm, ldy;
    w = 0;
    le = 0;
    @(negedge clk);
    load = ld; en = e; load_yy = yy; load_mm = mm; load_dd = dd;
    if (ld) begin
      le = 1;
      if (nib_ok(yy) && nib_ok(mm) && nib_ok(dd)) begin
        ly = from_bcd(yy); lm = from_bcd(mm); ldy = from_bcd(dd);
        if (lm >= 1 && lm <= 12) begin
          if (ldy >= 1 && ldy <= dim(lm, ly)) begin
            le = 0;
            m_year = ly; m_month = lm; m_day = ldy;
          end
        end
      end
    end else if (e) begin
      m_day++;
      if (m_day > dim(m_month, m_year)) begin
        m_day = 1;
        m_month++;
        if (m_month > 12) begin
          m_month = 1;
          m_year++;
          if (m_year > 99) begin
            m_year = 0;
            w = 1;
          end
        end
      end
    end
    exp_q.push_back({to_bcd(m_year), to_bcd(m_month), to_bcd(m_day), w, le});
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic tick();
    step(0, 1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic ld(input logic [7:0] yy, input logic [7:0] mm, input logic [7:0] dd);
    step(1, 0, yy, mm, dd);
  endtask

  // Scoreboard monitor: every live cycle the DUT presents a date; compare it
  always begin
    @(posedge clk);
    #1;
    if (rst_n && exp_q.size() > 0)
      check("scoreboard", actual, exp_q.pop_front());
  end

  task automatic mid_reset();
    @(negedge clk);
    load = 0; en = 1;
    rst_n = 0;
    #1;
    check("async_reset", actual, {8'h00, 8'h01, 8'h01, 2'b00});
    m_year = 0; m_month = 1; m_day = 1;
    @(negedge clk);
    en = 0;
    rst_n = 1;
  endtask

  initial begin
    int r, y, m, d;
    logic [7:0] yy, mm, dd;
    repeat (2) @(negedge clk);
    check("reset_state", actual, {8'h00, 8'h01, 8'h01, 2'b00});
    rst_n = 1;

    ld(8'h24, 8'h02, 8'h28); tick(); tick(); idle();
    ld(8'h23, 8'h02, 8'h28); tick(); ld(8'h00, 8'h02, 8'h29); idle();
    ld(8'h99, 8'h12, 8'h31); tick(); idle(); idle();
    ld(8'h19, 8'h04, 8'h30); tick(); idle();
    ld(8'h21, 8'h02, 8'h30); idle(); ld(8'h21, 8'h13, 8'h01); ld(8'h21, 8'h0A, 8'h05); idle();
    step(1, 1, 8'h21, 8'h06, 8'h09); tick(); idle();
    ld(8'h21, 8'h02, 8'h30); step(1, 1, 8'h21, 8'h02, 8'h30); idle();
    ld(8'h21, 8'h06, 8'h0F); ld(8'hA1, 8'h06, 8'h01); ld(8'h21, 8'h06, 8'h00);
    ld(8'h21, 8'h04, 8'h31); ld(8'h20, 8'h02, 8'h29); ld(8'h00, 8'h00, 8'h01);
    tick(); tick();
    mid_reset();
    idle(); tick();

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        y = $urandom_range(0, 99);
        m = $urandom_range(1, 12);
        d = ($urandom_range(0, 1) == 0) ? dim(m, y) : $urandom_range(1, dim(m, y));
        if (r == 0) begin y = 99; m = 12; d = $urandom_range(25, 31); end
        step(1, 1'($urandom_range(0, 1)), to_bcd(y), to_bcd(m), to_bcd(d));
      end else if (r < 13) begin
        y = $urandom_range(0, 99);
        m = $urandom_range(1, 12);
        yy = to_bcd(y); mm = to_bcd(m); dd = to_bcd(dim(m, y) + 1);
        case ($urandom_range(0, 3))
          0: begin yy = 8'($urandom); mm = 8'($urandom); dd = 8'($urandom); end
          1: ;
          2: mm = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h13;
          default: dd = 8'h00;
        endcase
        step(1, 1'($urandom_range(0, 1)), yy, mm, dd);
      end else begin
        step(0, r < 85, 8'($urandom), 8'($urandom), 8'($urandom));
      end
    end

    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
